program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/microarch_defs_pkg.sv | 20 ++
 rtl/loader_checksum.sv | 17 +
 rtl/program_loader.sv | 93 +++++++++
 tb/tb_program_loader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/microarch_defs_pkg.sv
// microarch_defs: shared microarchitecture types (instruction format, loader FSM states, limits)
package microarch_defs;
  localparam int LOADER_PROG_LEN_MAX = 16;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;
  typedef struct packed {
    opcode_t    opcode;
    logic [3:0] operand;
  } instruction_t;
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} loader_state_t;
endpackage

// File: rtl/loader_checksum.sv
// loader_checksum: modulo-256 running sum of program bytes
// Ports: clk, reset (async, active-high), clear (sum<=0), enable (add byte_in), byte_in[7:0], sum[7:0]
module loader_checksum
  import microarch_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] byte_in,
  output logic [7:0] sum
);
  always_ff @(posedge clk or posedge reset)
    if (reset) sum <= '0;
    else if (clear) sum <= '0;
    else if (enable) sum <= sum + byte_in;
endmodule

// File: rtl/program_loader.sv
// program_loader: streams PROG_LEN instruction bytes into program RAM while holding the CPU
// Ports: clk, reset (async, active-high), start, byte_in[7:0], byte_valid, byte_ready,
//        ram_we, ram_addr[ADDR_W-1:0], ram_data[7:0], cpu_hold, done, error
// Optional: define LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte;
//           otherwise error is tied low and the CHECK state is never entered.
module program_loader
  import microarch_defs::*;
#(
  parameter int PROG_LEN = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  loader_state_t     state;
  logic [ADDR_W-1:0] cnt;
  logic              hs, wr, last, go;
  assign hs   = byte_valid && byte_ready;
  assign wr   = hs && state == LOAD;
  assign last = cnt == ADDR_W'(PROG_LEN - 1);
  assign go   = start && (state == IDLE || state == DONE);
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
  logic [7:0] sum;
  loader_checksum u_sum (
    .clk     (clk),
    .reset   (reset),
    .clear   (go),
    .enable  (wr),
    .byte_in (byte_in),
    .sum     (sum)
  );
  // sum already includes every program byte when the trailer arrives in CHECK
  always_ff @(posedge clk or posedge reset)
    if (reset) error <= 1'b0;
    else if (go) error <= 1'b0;
    else if (hs && state == CHECK) error <= byte_in != sum;
`else
  localparam bit CK = 1'b0;
  assign error = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      byte_ready <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
    end else begin
      ram_we <= wr;
      if (wr) begin
        ram_addr <= cnt;
        ram_data <= byte_in;
      end
      case (state)
        IDLE, DONE: if (start) begin
          state      <= LOAD;
          cnt        <= '0;
          byte_ready <= 1'b1;
          cpu_hold   <= 1'b1;
          done       <= 1'b0;
        end
        LOAD: if (hs) begin
          if (last) begin
            state      <= CK ? CHECK : DONE;
            byte_ready <= CK;
            cpu_hold   <= CK;
            done       <= !CK;
          end else cnt <= cnt + 1'b1;
        end
        CHECK: if (hs) begin
          state      <= DONE;
          byte_ready <= 1'b0;
          cpu_hold   <= 1'b0;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized and directed checks of program_loader against a behavioural model
module tb_program_loader;
  localparam int PROG_LEN = 16;
  localparam int ADDR_W   = 4;
  localparam int VW       = ADDR_W + 13;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        byte_in = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready, ram_we, cpu_hold, done, error;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  int vectors = 0;
  int fails = 0;
  program_loader #(.PROG_LEN(PROG_LEN), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );
  always #5 clk = ~clk;
  // model: phase 0 idle, 1 receiving program, 2 awaiting checksum, 3 finished
  int                phase;
  int                nxt;
  logic [7:0]        m_sum;
  logic              m_err, e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [7:0]        e_data;
  function automatic logic [VW-1:0] obs();
    return {byte_ready, ram_we, ram_addr, ram_data, cpu_hold, done, error};
  endfunction
  function automatic logic [VW-1:0] expv();
    return {phase == 1 || phase == 2, e_we, e_addr, e_data, phase != 3, phase == 3, m_err};
  endfunction
  task automatic model_reset();
    phase = 0; nxt = 0; m_sum = '0; m_err = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0;
  endtask
  // drive one cycle, advance the model, leave time at 1 after the rising edge
  task automatic step(input bit s, input bit v, input logic [7:0] d);
    bit acc;
    start = s; byte_valid = v; byte_in = d;
    acc = v && (phase == 1 || phase == 2);
    @(posedge clk);
    #1;
    e_we = acc && phase == 1;
    if (e_we) begin
      e_addr = ADDR_W'(nxt);
      e_data = d;
    end
    if (s && (phase == 0 || phase == 3)) begin
      phase = 1; nxt = 0; m_sum = '0; m_err = 1'b0;
    end else if (acc && phase == 1) begin
      m_sum = m_sum + d;
      if (nxt == PROG_LEN - 1) phase = CK ? 2 : 3;
      else nxt++;
    end else if (acc && phase == 2) begin
      m_err = d != m_sum;
      phase = 3;
    end
  endtask
  task automatic test_reset();
    reset = 1'b1; start = 0; byte_valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs() !== expv()) begin
      fails++;
      $display("FAIL reset: got [rdy we addr data hold done err]=%b expected %b", obs(), expv());
    end
    @(negedge clk) reset = 1'b0;
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      step(i == 0, i >= 1 && i <= PROG_LEN + int'(CK), 8'(8'h10 + i - 1));
      vectors++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL back_to_back cyc%0d: got %b expected %b", i, obs(), expv());
      end
    end
  endtask
  task automatic test_toggle();
    for (int i = 0; i < 2 * PROG_LEN + 8; i++) begin
      step(i == 0, i[0], 8'($urandom));
      vectors++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL toggle cyc%0d: got %b expected %b", i, obs(), expv());
      end
    end
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) begin
      step(i == 0, i > 0, 8'($urandom));
      vectors++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL reset_mid load cyc%0d: got %b expected %b", i, obs(), expv());
      end
    end
    reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (obs() !== expv()) begin
      fails++;
      $display("FAIL reset_mid async: got %b expected %b", obs(), expv());
    end
    reset = 1'b0;
    for (int i = 0; i < PROG_LEN + 4; i++) begin
      step(i == 0, i > 0, 8'($urandom));
      vectors++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL reset_mid reload cyc%0d: got %b expected %b", i, obs(), expv());
      end
    end
  endtask
  task automatic test_start_mid();
    for (int i = 0; i < PROG_LEN + 4; i++) begin
      step(i == 0 || i == 8 || i == 9, i > 0, 8'($urandom));
      vectors++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL start_mid cyc%0d: got %b expected %b", i, obs(), expv());
      end
    end
  endtask
  task automatic test_idle_valid();
    reset = 1'b1;
    model_reset();
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < PROG_LEN + 10; i++) begin
      step(i == 3, i < 4 || i >= 5, 8'($urandom));
      vectors++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL idle_done_valid cyc%0d: got %b expected %b", i, obs(), expv());
      end
    end
  endtask
  task automatic test_checksum();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < PROG_LEN + 4; i++) begin
        step(i == 0, i > 0 && i <= PROG_LEN + 1, i == PROG_LEN + 1 ? 8'(8'h10 + r) : 8'h01);
        vectors++;
        if (obs() !== expv()) begin
          fails++;
          $display("FAIL checksum run%0d cyc%0d: got %b expected %b", r, i, obs(), expv());
        end
      end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, 8'($urandom));
      vectors++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL random cyc%0d: got %b expected %b", i, obs(), expv());
      end
    end
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_toggle();
    test_reset_mid();
    test_start_mid();
    test_idle_valid();
    test_checksum();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
